// File: rtl/cla_pipe_adder_if.sv
// rtl/cla_pipe_adder_if.sv - operand/result handshake bundle for cla_pipe_adder
//
// Purpose: groups the operand-side and result-side valid/ready channels of the
//          pipelined carry-lookahead adder.
// Signals:
//   in_valid / in_ready     operand pair handshake
//   a, b [WIDTH]            operands
//   cin                     carry into bit 0
//   sub                     subtract select (only when CLA_SUB_EN is defined)
//   out_valid / out_ready   result handshake
//   sum [WIDTH], cout, ovf  result, carry out, two's-complement overflow
// Modports: master = operand source / result sink, slave = the adder.
// Build option: CLA_SUB_EN adds the sub signal.

interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CLA_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef CLA_SUB_EN
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`endif
endinterface

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - three-stage pipelined two-level carry-lookahead adder
//
// Purpose: takes one operand pair per cycle, forms bit propagate/generate terms,
//          resolves group and intra-group carries purely through P/G lookahead
//          and returns sum, carry out and overflow. The result is valid three
//          clocks after the operand is presented (the accepting edge is the first
//          of the three) when downstream does not stall.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset; flushes every in-flight operation
//   bus     cla_pipe_adder_if.slave: in_valid/in_ready, a, b, cin, [sub],
//           out_valid/out_ready, sum, cout, ovf
// Parameters: WIDTH operand width (multiple of GROUP), GROUP bits per lookahead group.
// Build option: CLA_SUB_EN enables subtraction (b inverted, carry-in forced to 1).

module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input logic            clk,
  input logic            rst_n,
  cla_pipe_adder_if.slave bus
);
  localparam int NG = WIDTH / GROUP;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0_in;

  // stage 1
  logic             v1;
  logic [WIDTH-1:0] p1, g1;
  logic             c0_1;
  // stage 2
  logic             v2;
  logic [WIDTH-1:0] p2, g2;
  logic [NG:0]      gc2;
  // stage 3 (output)
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  logic [NG-1:0]    gp, gg;
  logic [NG:0]      cg;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_nxt;

  // Whole pipe moves as one; only a stalled valid result blocks it.
  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.ovf      = ovf_q;

  always_comb begin
`ifdef CLA_SUB_EN
    b_eff = bus.b ^ {WIDTH{bus.sub}};
    c0_in = bus.cin | bus.sub;
`else
    b_eff = bus.b;
    c0_in = bus.cin;
`endif
  end

  // Group propagate/generate, then the second-level carry chain across groups.
  always_comb begin
    gp = '0;
    gg = '0;
    cg = '0;
    cg[0] = c0_1;
    for (int k = 0; k < NG; k++) begin
      gp[k] = &p1[k*GROUP +: GROUP];
      gg[k] = g1[k*GROUP];
      for (int j = 1; j < GROUP; j++) begin
        gg[k] = g1[k*GROUP+j] | (p1[k*GROUP+j] & gg[k]);
      end
      cg[k+1] = gg[k] | (gp[k] & cg[k]);
    end
  end

  // Intra-group carries seeded by each group carry-in. The carry computed out of
  // the top of a group is overwritten by the lookahead carry of the next group;
  // both are equal, the lookahead one is the architectural source.
  always_comb begin
    c       = '0;
    sum_nxt = '0;
    for (int k = 0; k < NG; k++) begin
      c[k*GROUP] = gc2[k];
      for (int j = 0; j < GROUP; j++) begin
        c[k*GROUP+j+1]   = g2[k*GROUP+j] | (p2[k*GROUP+j] & c[k*GROUP+j]);
        sum_nxt[k*GROUP+j] = p2[k*GROUP+j] ^ c[k*GROUP+j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1          <= 1'b0;
      p1          <= '0;
      g1          <= '0;
      c0_1        <= 1'b0;
      v2          <= 1'b0;
      p2          <= '0;
      g2          <= '0;
      gc2         <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (adv) begin
      v1          <= bus.in_valid;
      p1          <= bus.a ^ b_eff;
      g1          <= bus.a & b_eff;
      c0_1        <= c0_in;
      v2          <= v1;
      p2          <= p1;
      g2          <= g1;
      gc2         <= cg;
      out_valid_q <= v2;
      sum_q       <= sum_nxt;
      cout_q      <= gc2[NG];
      ovf_q       <= c[WIDTH-1] ^ c[WIDTH];
    end
  end
endmodule
